// File: rtl/i2c_target_regs_pkg.sv
// Shared definitions for the I2C register target: protocol state encoding
// and byte width used by the pointer and shift register.
package i2c_target_defs;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_target_regs_line_filter.sv
// Input conditioning for one I2C line: 2-FF synchronizer followed by a
// stable-count filter. The filtered level only moves after FILTER_LEN equal
// consecutive samples of the new value; rise/fall pulse in the cycle it moves.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk_27M,
  input  logic reset,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

  logic       sync_p0;
  logic       sync_p1;
  logic [3:0] cnt;

  // Two-stage synchronizer; idle I2C lines are high, so reset to 1.
  always_ff @(posedge clk_27M or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Count consecutive samples that disagree with the filtered level; flip once enough agree.
  always_ff @(posedge clk_27M or posedge reset) begin
    if (reset) begin
      lvl  <= 1'b1;
      cnt  <= 4'd0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_p1 == lvl) begin
        cnt <= 4'd0;
      end else if (cnt == LAST) begin
        lvl  <= sync_p1;
        cnt  <= 4'd0;
        rise <= sync_p1;
        fall <= ~sync_p1;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit auto-incrementing register pointer and a byte-wide
// register bus. First written byte sets the pointer, later bytes are register
// writes; reads stream bytes from the pointer onward. No clock stretching.
module i2c_target_regs
  import i2c_target_defs::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h5A,
  parameter int         FILTER_LEN  = 4
) (
  input  logic              clk_27M,
  input  logic              reset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_t,
  output logic [BYTE_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              busy,
  output logic              selected
);

  function automatic logic [BYTE_W-1:0] ptr_inc(input logic [BYTE_W-1:0] p);
    return p + 8'd1;
  endfunction

  logic scl_lv, scl_rise, scl_fall;
  logic sda_lv, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk_27M (clk_27M),
    .reset   (reset),
    .din     (scl_i),
    .lvl     (scl_lv),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk_27M (clk_27M),
    .reset   (reset),
    .din     (sda_i),
    .lvl     (sda_lv),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shift_q;
  logic              first_q;
  logic              rw_q;
  logic              ack_hi_q;
  logic              scl_fall_p1;
  logic              rdata_vld_p1;
  logic              rdata_vld_p2;
  logic              sda_rel_d;

  logic              start_c, stop_c, last_bit, addr_match;
  logic [BYTE_W-1:0] byte_in;

  assign start_c    = sda_fall & scl_lv;
  assign stop_c     = sda_rise & scl_lv;
  assign byte_in    = {shift_q[6:0], sda_lv};
  assign last_bit   = scl_rise && (bit_cnt == 3'd7);
  assign addr_match = (byte_in[7:1] == TARGET_ADDR);
  assign sda_o      = 1'b0;

  // State register.
  always_ff @(posedge clk_27M or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: bus conditions beat any SCL edge on the same cycle.
  always_comb begin
    state_d = state_q;
    if (stop_c) begin
      state_d = IDLE;
    end else if (start_c) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR:     if (last_bit) state_d = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall && ack_hi_q) state_d = rw_q ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (last_bit) state_d = WR_ACK;
        WR_ACK:   if (scl_fall && ack_hi_q) state_d = WR_BYTE;
        RD_BYTE:  if (last_bit) state_d = RD_ACK;
        RD_ACK:   if (scl_rise) state_d = sda_lv ? IGNORE : RD_BYTE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Desired SDA release for the current state; a read byte stays released until its data lands.
  always_comb begin
    sda_rel_d = 1'b1;
    case (state_q)
      ADDR_ACK, WR_ACK: sda_rel_d = 1'b0;
      RD_BYTE:          sda_rel_d = (reg_re || rdata_vld_p1) ? 1'b1 : shift_q[7];
      default:          sda_rel_d = 1'b1;
    endcase
  end

  // Bit shifting, pointer/register bus strobes, status flags and the SDA driver.
  always_ff @(posedge clk_27M or posedge reset) begin
    if (reset) begin
      bit_cnt      <= 3'd0;
      shift_q      <= '0;
      first_q      <= 1'b0;
      rw_q         <= 1'b0;
      ack_hi_q     <= 1'b0;
      scl_fall_p1  <= 1'b0;
      rdata_vld_p1 <= 1'b0;
      rdata_vld_p2 <= 1'b0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      reg_we       <= 1'b0;
      reg_re       <= 1'b0;
      busy         <= 1'b0;
      selected     <= 1'b0;
      sda_t        <= 1'b1;
    end else begin
      // Stage p1: delayed SCL fall and read-data valid; p2: data now in the shift register.
      scl_fall_p1  <= scl_fall;
      rdata_vld_p1 <= reg_re;
      rdata_vld_p2 <= rdata_vld_p1;
      reg_re       <= 1'b0;
      reg_we       <= 1'b0;
      if (reg_we)       reg_addr <= ptr_inc(reg_addr);
      if (rdata_vld_p1) shift_q  <= reg_rdata;

      if (stop_c) begin
        busy     <= 1'b0;
        selected <= 1'b0;
        sda_t    <= 1'b1;
      end else if (start_c) begin
        busy     <= 1'b1;
        selected <= 1'b0;
        bit_cnt  <= 3'd0;
        sda_t    <= 1'b1;
      end else begin
        // The post-load update only fires with SCL low so SDA never moves while SCL is high.
        if (scl_fall_p1 || (rdata_vld_p2 && !scl_lv)) sda_t <= sda_rel_d;
        case (state_q)
          ADDR: if (scl_rise) begin
            shift_q <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rw_q     <= byte_in[0];
              ack_hi_q <= 1'b0;
              if (addr_match) selected <= 1'b1;
            end
          end
          ADDR_ACK: if (scl_rise) begin
            ack_hi_q <= 1'b1;
          end else if (scl_fall && ack_hi_q) begin
            bit_cnt <= 3'd0;
            if (rw_q) reg_re  <= 1'b1;
            else      first_q <= 1'b1;
          end
          WR_BYTE: if (scl_rise) begin
            shift_q <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ack_hi_q <= 1'b0;
              if (first_q) begin
                reg_addr <= byte_in;
                first_q  <= 1'b0;
              end else begin
                reg_wdata <= byte_in;
                reg_we    <= 1'b1;
              end
            end
          end
          WR_ACK: if (scl_rise) begin
            ack_hi_q <= 1'b1;
          end else if (scl_fall && ack_hi_q) begin
            bit_cnt <= 3'd0;
          end
          RD_BYTE: if (scl_rise) begin
            shift_q <= {shift_q[6:0], 1'b1};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) reg_addr <= ptr_inc(reg_addr);
          end
          RD_ACK: if (scl_rise) begin
            if (!sda_lv) begin
              reg_re  <= 1'b1;
              bit_cnt <= 3'd0;
            end else begin
              selected <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master, a register-file peer,
// and a transaction-level reference model feeding a strobe scoreboard.
`timescale 1ns/1ps
module tb_i2c_target_regs;

  localparam logic [6:0] TADDR = 7'h5A;
  localparam int HALF = 20;

  logic       clk_27M = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       scl_i, sda_i;
  logic       sda_o, sda_t;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy, selected;

  int checks = 0;
  int errors = 0;

  logic [7:0]  peer_mem [0:255];
  logic [7:0]  m_mem    [0:255];
  logic [7:0]  m_ptr;
  logic [7:0]  wbuf     [0:15];
  logic        glitch_en = 1'b0;
  logic [15:0] exp_we [$];
  logic [7:0]  exp_re [$];
  logic [15:0] mon_we;
  logic [7:0]  mon_re;

  always #18.5 clk_27M = ~clk_27M;

  // Open-drain bus: anyone pulling low wins.
  assign scl_i = scl_m;
  assign sda_i = sda_m & (sda_t ? 1'b1 : sda_o);

  i2c_target_regs #(.TARGET_ADDR(TADDR), .FILTER_LEN(4)) dut (
    .clk_27M   (clk_27M),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .selected  (selected)
  );

  // Register-file peer: answers reg_re with data on the following cycle.
  always @(posedge clk_27M) begin
    if (reg_we) peer_mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= peer_mem[reg_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every strobe pops the next expected transaction.
  always @(negedge clk_27M) begin
    if (!reset) begin
      if (reg_we || reg_re) check("we_re_exclusive", {31'd0, reg_we & reg_re}, 32'd0);
      if (reg_we) begin
        if (exp_we.size() == 0) check("we_unexpected", {16'd0, reg_addr, reg_wdata}, 32'hFFFF_FFFF);
        else begin
          mon_we = exp_we.pop_front();
          check("we_addr", reg_addr, mon_we[15:8]);
          check("we_data", reg_wdata, mon_we[7:0]);
        end
      end
      if (reg_re) begin
        if (exp_re.size() == 0) check("re_unexpected", reg_addr, 32'hFFFF_FFFF);
        else begin
          mon_re = exp_re.pop_front();
          check("re_addr", reg_addr, mon_re);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_27M);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic r);
    tick(6);
    sda_m = b;
    if (glitch_en) begin
      tick(4); scl_m = 1'b1; tick(2); scl_m = 1'b0; tick(HALF - 12);
    end else tick(HALF - 6);
    scl_m = 1'b1;
    tick(HALF / 2);
    r = sda_i;
    if (glitch_en) begin
      sda_m = ~b; tick(2); sda_m = b; tick(HALF / 2 - 2);
    end else tick(HALF / 2);
    scl_m = 1'b0;
  endtask

  task automatic start_cond();
    if (scl_m == 1'b0) begin
      tick(6); sda_m = 1'b1; tick(HALF - 6); scl_m = 1'b1; tick(HALF);
    end
    sda_m = 1'b0;
    tick(HALF);
    scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    tick(6); sda_m = 1'b0; tick(HALF - 6);
    scl_m = 1'b1; tick(HALF);
    sda_m = 1'b1; tick(HALF);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    send_bit(1'b1, r);
    acked = ~r;
  endtask

  task automatic rd_byte(output logic [7:0] b, input logic mack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      b[i] = r;
    end
    send_bit(~mack, r);
  endtask

  task automatic end_checks();
    check("busy_after_stop", busy, 0);
    check("sel_after_stop", selected, 0);
    check("reg_addr", reg_addr, m_ptr);
    check("we_pending", exp_we.size(), 0);
    check("re_pending", exp_re.size(), 0);
  endtask

  // Write transaction: wbuf[0] is the pointer, the rest are register data.
  task automatic do_write(input logic [6:0] a, input int n, input logic with_stop);
    logic ack, sel;
    sel = (a == TADDR);
    start_cond();
    wr_byte({a, 1'b0}, ack);
    check("addr_ack", ack, sel);
    check("selected", selected, sel);
    check("busy", busy, 1);
    for (int k = 0; k < n; k++) begin
      if (sel) begin
        if (k == 0) m_ptr = wbuf[0];
        else begin
          exp_we.push_back({m_ptr, wbuf[k]});
          m_mem[m_ptr] = wbuf[k];
          m_ptr = 8'((int'(m_ptr) + 1) % 256);
        end
      end
      wr_byte(wbuf[k], ack);
      check("data_ack", ack, sel);
    end
    if (with_stop) begin
      stop_cond(); tick(4); end_checks();
    end
  endtask

  // Read transaction from the current pointer; master NACKs the last byte.
  task automatic do_read(input int n);
    logic ack;
    logic [7:0] b;
    logic [7:0] expb [0:15];
    for (int k = 0; k < n; k++) begin
      exp_re.push_back(m_ptr);
      expb[k] = m_mem[m_ptr];
      m_ptr = 8'((int'(m_ptr) + 1) % 256);
    end
    start_cond();
    wr_byte({TADDR, 1'b1}, ack);
    check("rd_addr_ack", ack, 1);
    check("rd_selected", selected, 1);
    for (int k = 0; k < n; k++) begin
      rd_byte(b, k != n - 1);
      check("rd_data", b, expb[k]);
    end
    check("nack_deselect", selected, 0);
    stop_cond(); tick(4); end_checks();
  endtask

  task automatic reset_value_checks(input string tag);
    check({tag, "_sda_t"}, sda_t, 1);
    check({tag, "_sda_o"}, sda_o, 0);
    check({tag, "_reg_addr"}, reg_addr, 0);
    check({tag, "_reg_wdata"}, reg_wdata, 0);
    check({tag, "_reg_we"}, reg_we, 0);
    check({tag, "_reg_re"}, reg_re, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_selected"}, selected, 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack, r;
    logic [7:0] v;
    int nd;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      peer_mem[i] = v;
      m_mem[i]    = v;
    end
    m_ptr = 8'h00;
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    tick(5);
    reset_value_checks("reset");
    reset = 1'b0;
    tick(10);

    // Pointer 41, one data byte.
    wbuf[0] = 8'h41; wbuf[1] = 8'h0F;
    do_write(TADDR, 2, 1'b1);

    // Pointer 00, repeated START, read three bytes.
    peer_mem[0] = 8'h12; peer_mem[1] = 8'h34; peer_mem[2] = 8'h56;
    m_mem[0]    = 8'h12; m_mem[1]    = 8'h34; m_mem[2]    = 8'h56;
    wbuf[0] = 8'h00;
    do_write(TADDR, 1, 1'b0);
    do_read(3);
    check("read_ptr_03", reg_addr, 8'h03);

    // Foreign address: everything NACKed.
    wbuf[0] = 8'h41;
    do_write(7'h5B, 1, 1'b1);

    // Pointer wrap FF -> 00.
    wbuf[0] = 8'hFF; wbuf[1] = 8'hAA; wbuf[2] = 8'hBB;
    do_write(TADDR, 3, 1'b1);
    check("wrap_ptr_01", reg_addr, 8'h01);

    // Reset in the middle of a read byte while the target pulls SDA low.
    m_mem[8'h30] = 8'h00; peer_mem[8'h30] = 8'h00;
    wbuf[0] = 8'h30;
    do_write(TADDR, 1, 1'b0);
    exp_re.push_back(8'h30);
    start_cond();
    wr_byte({TADDR, 1'b1}, ack);
    check("rst_rd_ack", ack, 1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, r);
    tick(14);
    check("rst_pre_drive", sda_t, 0);
    #5 reset = 1'b1;
    #1 reset_value_checks("midreset");
    scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    check("rst_re_consumed", exp_re.size(), 0);
    m_ptr = 8'h00;

    // Short glitches on an idle bus, then a write with glitches on every bit.
    scl_m = 1'b0; tick(2); scl_m = 1'b1; tick(10);
    sda_m = 1'b0; tick(2); sda_m = 1'b1; tick(10);
    check("glitch_idle_busy", busy, 0);
    glitch_en = 1'b1;
    wbuf[0] = 8'h10; wbuf[1] = 8'h5C; wbuf[2] = 8'hA3;
    do_write(TADDR, 3, 1'b1);
    glitch_en = 1'b0;

    // Randomized transactions against the reference model.
    for (int t = 0; t < 10; t++) begin
      wbuf[0] = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      nd = $urandom_range(1, 4);
      for (int k = 1; k <= nd; k++) wbuf[k] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 5) == 0)
          do_write(TADDR ^ 7'($urandom_range(1, 127)), nd + 1, 1'b1);
        else
          do_write(TADDR, nd + 1, 1'b1);
      end else begin
        do_write(TADDR, 1, 1'b0);
        do_read(nd);
      end
    end

    tick(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
